// File: rtl/filter_ctrl_pkg.sv
// Shared types and defaults for the filter frame sequencer.
package filter_ctrl_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int LEN_W_DEF  = 15;

  // Filter sample format (sfix10_En3): passed through bit-for-bit, never re-scaled here.
  typedef logic signed [DATA_W_DEF-1:0] sfix10_en3_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/filter_lat_tracker.sv
// Tag shift register that mirrors the filter pipeline, marking which
// clk_enable slots carry a real sample rather than a flush zero.
module filter_lat_tracker #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic ce,
  input  logic tag_in,
  output logic tag_out
);

  logic [LATENCY-1:0] tag_sr;

  generate
    if (LATENCY == 1) begin : g_single
      // Single-stage pipeline: the tag is just the last slot's marker.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)  tag_sr <= '0;
        else if (clr) tag_sr <= '0;
        else if (ce)  tag_sr <= tag_in;
      end
    end else begin : g_chain
      // Advance the tags in lockstep with the filter's clk_enable.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)  tag_sr <= '0;
        else if (clr) tag_sr <= '0;
        else if (ce)  tag_sr <= {tag_sr[LATENCY-2:0], tag_in};
      end
    end
  endgenerate

  assign tag_out = tag_sr[LATENCY-1];

endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer around a clk_enable-gated filter: pulls frame_len samples
// upstream, flushes the pipeline with zeros and streams frame_len outputs.
module filter_frame_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              filt_reset,
  output logic              filt_ce,
  output logic [DATA_W-1:0] filt_in,
  input  logic [DATA_W-1:0] filt_out,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  state_t            state, next_state;
  logic [LEN_W-1:0]  len_q, in_cnt, out_cnt;
  logic              stall, handshake, capture;
  logic              tag_in, tag_out, tag_clr;

  // A held output blocks the filter so a fresh capture can never overwrite it.
  assign stall     = m_valid & ~m_ready;
  assign handshake = m_valid & m_ready;
  assign capture   = filt_ce & tag_out;
  assign tag_clr   = (state == CLEAR) | abort;

  filter_lat_tracker #(.LATENCY(LATENCY)) u_tracker (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (tag_clr),
    .ce      (filt_ce),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Next-state and the combinational stream/filter controls.
  always_comb begin
    next_state = state;
    filt_ce    = 1'b0;
    s_ready    = 1'b0;
    filt_in    = '0;
    tag_in     = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = (frame_len == '0) ? DONE : CLEAR;
      end
      CLEAR: begin
        next_state = RUN;
      end
      RUN: begin
        filt_ce = s_valid & ~stall;
        s_ready = filt_ce;
        filt_in = s_data;
        tag_in  = 1'b1;
        if (filt_ce && (in_cnt == len_q - LEN_W'(1))) next_state = FLUSH;
      end
      FLUSH: begin
        // Only clock the pipeline while real samples are still inside it.
        filt_ce = ~stall & (out_cnt != len_q);
        if ((out_cnt == len_q) && !m_valid) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (abort) next_state = IDLE;
  end

  // State register plus status outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      filt_reset <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= (next_state != IDLE);
      done       <= (next_state == DONE);
      filt_reset <= (next_state == CLEAR);
    end
  end

  // Frame length latch and input/output beat counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (abort) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      len_q   <= frame_len;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if ((state == RUN) && filt_ce) in_cnt <= in_cnt + LEN_W'(1);
      if (capture)                   out_cnt <= out_cnt + LEN_W'(1);
    end
  end

  // Downstream output register; capture wins over a simultaneous handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (abort) begin
      m_valid <= 1'b0;
    end else if (capture) begin
      m_valid <= 1'b1;
      m_data  <= filt_out;
    end else if (handshake) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Randomized bench for filter_frame_ctrl with a behavioural latency-2 filter
// and a queue model: outputs must be fn(accepted samples) in order, exactly frame_len.
module tb_filter_frame_ctrl;

  localparam int DATA_W  = 10;
  localparam int LEN_W   = 15;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  frame_len = '0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready, filt_reset, filt_ce, m_valid, busy, done;
  logic [DATA_W-1:0] filt_in, filt_out, m_data;
  logic              m_ready = 1'b0;

  logic [DATA_W-1:0] flt_r1 = '0;
  logic [DATA_W-1:0] flt_r2 = '0;

  int n_checks = 0;
  int n_pass   = 0;

  int n_in, n_out, n_data_err, n_run_ce, n_flush_ce, n_done, n_stall_viol;
  int n_clear, n_mvalid, n_ce_in_clear;
  bit timed_out, end_mv, end_done, end_busy, rst_hit;
  logic [7:0] rst_vec;
  logic [DATA_W-1:0] exp_q[$];

  filter_frame_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .frame_len  (frame_len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .filt_reset (filt_reset),
    .filt_ce    (filt_ce),
    .filt_in    (filt_in),
    .filt_out   (filt_out),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] filt_fn(input logic [DATA_W-1:0] x);
    return DATA_W'(x * 5 + 7);
  endfunction

  // Golden filter: two clk_enable stages, output = fn(input two enables ago).
  always @(posedge clk) begin
    if (filt_reset) begin
      flt_r1 <= '0;
      flt_r2 <= '0;
    end else if (filt_ce) begin
      flt_r1 <= filt_in;
      flt_r2 <= filt_fn(flt_r1);
    end
  end
  assign filt_out = flt_r2;

  task automatic run_frame(input int len, input int sv_pct, input int mr_mode,
                           input int abort_at, input int start_at, input bit rst_in_flush);
    int cyc, max_cyc;
    bit aborted, restarted;
    logic [DATA_W-1:0] exp_v;
    n_in = 0; n_out = 0; n_data_err = 0; n_run_ce = 0; n_flush_ce = 0; n_done = 0;
    n_stall_viol = 0; n_clear = 0; n_mvalid = 0; n_ce_in_clear = 0;
    timed_out = 0; rst_hit = 0; rst_vec = '0;
    aborted = 0; restarted = 0;
    exp_q.delete();
    max_cyc = len * 20 + 100;
    cyc = 0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      start     = (cyc == 0);
      frame_len = (cyc == 0) ? LEN_W'(len) : LEN_W'(3);
      if (cyc > 0 && start_at >= 0 && !restarted && n_in == start_at) begin
        start = 1'b1;
        restarted = 1;
      end
      abort = 1'b0;
      if (cyc > 0 && abort_at >= 0 && !aborted && n_in == abort_at) begin
        abort = 1'b1;
        aborted = 1;
      end
      s_valid = ($urandom_range(99) < sv_pct);
      s_data  = DATA_W'($urandom);
      case (mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = cyc[0];
        default: m_ready = 1'($urandom_range(1));
      endcase
      #1;
      if (s_valid && s_ready) begin
        exp_q.push_back(filt_fn(s_data));
        n_in++;
      end
      if (filt_ce) begin
        if (m_valid && !m_ready) n_stall_viol++;
        if (s_ready) n_run_ce++;
        else         n_flush_ce++;
      end
      if (filt_reset) begin
        n_clear++;
        if (filt_ce) n_ce_in_clear++;
      end
      if (m_valid) n_mvalid++;
      if (m_valid && m_ready) begin
        n_out++;
        if (exp_q.size() == 0) n_data_err++;
        else begin
          exp_v = exp_q.pop_front();
          if (m_data !== exp_v) n_data_err++;
        end
      end
      if (done) n_done++;
      if (rst_in_flush && busy && filt_ce && !s_ready) begin
        resetn = 1'b0;
        #1;
        rst_vec = {busy, m_valid, done, filt_reset, s_ready, filt_ce, |m_data, |filt_in};
        rst_hit = 1;
        break;
      end
      if (cyc > 0 && !busy) break;
      cyc++;
    end
    timed_out = (cyc >= max_cyc);
    end_mv = m_valid; end_done = done; end_busy = busy;
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    if (rst_hit) begin
      @(negedge clk);
      resetn = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if ({s_ready, filt_reset, filt_ce, m_valid, busy, done} !== 6'b0)
      $display("[TB] FAIL reset_ctrl got %b want 000000", {s_ready, filt_reset, filt_ce, m_valid, busy, done}); else n_pass++;
    n_checks++; if (filt_in !== '0) $display("[TB] FAIL reset_filt_in got %0h want 0", filt_in); else n_pass++;
    n_checks++; if (m_data !== '0) $display("[TB] FAIL reset_m_data got %0h want 0", m_data); else n_pass++;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if ({s_ready, filt_reset, filt_ce, m_valid, busy, done} !== 6'b0)
      $display("[TB] FAIL idle_ctrl got %b want 000000", {s_ready, filt_reset, filt_ce, m_valid, busy, done}); else n_pass++;
  endtask

  task automatic test_long_frame();
    run_frame(2000, 100, 0, -1, -1, 0);
    n_checks++; if (timed_out) $display("[TB] FAIL long_timeout got 1 want 0"); else n_pass++;
    n_checks++; if (n_in !== 2000) $display("[TB] FAIL long_in got %0d want 2000", n_in); else n_pass++;
    n_checks++; if (n_run_ce !== 2000) $display("[TB] FAIL long_run_ce got %0d want 2000", n_run_ce); else n_pass++;
    n_checks++; if (n_flush_ce !== LATENCY) $display("[TB] FAIL long_flush_ce got %0d want %0d", n_flush_ce, LATENCY); else n_pass++;
    n_checks++; if (n_out !== 2000) $display("[TB] FAIL long_out got %0d want 2000", n_out); else n_pass++;
    n_checks++; if (n_data_err !== 0) $display("[TB] FAIL long_data errors got %0d want 0", n_data_err); else n_pass++;
    n_checks++; if (n_done !== 1) $display("[TB] FAIL long_done cycles got %0d want 1", n_done); else n_pass++;
    n_checks++; if (n_clear !== 1) $display("[TB] FAIL long_clear cycles got %0d want 1", n_clear); else n_pass++;
    n_checks++; if (n_ce_in_clear !== 0) $display("[TB] FAIL long_ce_in_clear got %0d want 0", n_ce_in_clear); else n_pass++;
    n_checks++; if (end_busy !== 1'b0) $display("[TB] FAIL long_idle busy got %b want 0", end_busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    run_frame(8, 60, 1, -1, -1, 0);
    n_checks++; if (timed_out) $display("[TB] FAIL bp_timeout got 1 want 0"); else n_pass++;
    n_checks++; if (n_stall_viol !== 0) $display("[TB] FAIL bp_ce_during_stall got %0d want 0", n_stall_viol); else n_pass++;
    n_checks++; if (n_out !== 8) $display("[TB] FAIL bp_out got %0d want 8", n_out); else n_pass++;
    n_checks++; if (n_data_err !== 0) $display("[TB] FAIL bp_data errors got %0d want 0", n_data_err); else n_pass++;
    n_checks++; if (n_flush_ce !== LATENCY) $display("[TB] FAIL bp_flush_ce got %0d want %0d", n_flush_ce, LATENCY); else n_pass++;
    n_checks++; if (n_done !== 1) $display("[TB] FAIL bp_done cycles got %0d want 1", n_done); else n_pass++;
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int len;
      len = $urandom_range(40, 1);
      run_frame(len, $urandom_range(100, 30), 2, -1, -1, 0);
      n_checks++; if (timed_out) $display("[TB] FAIL rnd%0d_timeout got 1 want 0", f); else n_pass++;
      n_checks++; if (n_out !== len) $display("[TB] FAIL rnd%0d_out got %0d want %0d", f, n_out, len); else n_pass++;
      n_checks++; if (n_data_err !== 0) $display("[TB] FAIL rnd%0d_data errors got %0d want 0", f, n_data_err); else n_pass++;
      n_checks++; if (n_stall_viol !== 0) $display("[TB] FAIL rnd%0d_ce_during_stall got %0d want 0", f, n_stall_viol); else n_pass++;
      n_checks++; if (n_flush_ce !== LATENCY) $display("[TB] FAIL rnd%0d_flush_ce got %0d want %0d", f, n_flush_ce, LATENCY); else n_pass++;
      n_checks++; if (n_done !== 1) $display("[TB] FAIL rnd%0d_done cycles got %0d want 1", f, n_done); else n_pass++;
    end
  endtask

  task automatic test_zero_len();
    run_frame(0, 100, 0, -1, -1, 0);
    n_checks++; if (timed_out) $display("[TB] FAIL zero_timeout got 1 want 0"); else n_pass++;
    n_checks++; if (n_done !== 1) $display("[TB] FAIL zero_done cycles got %0d want 1", n_done); else n_pass++;
    n_checks++; if (n_run_ce + n_flush_ce !== 0) $display("[TB] FAIL zero_ce got %0d want 0", n_run_ce + n_flush_ce); else n_pass++;
    n_checks++; if (n_mvalid !== 0) $display("[TB] FAIL zero_m_valid got %0d want 0", n_mvalid); else n_pass++;
    n_checks++; if (n_clear !== 0) $display("[TB] FAIL zero_clear got %0d want 0", n_clear); else n_pass++;
    n_checks++; if (end_busy !== 1'b0) $display("[TB] FAIL zero_idle busy got %b want 0", end_busy); else n_pass++;
  endtask

  task automatic test_abort();
    run_frame(16, 80, 2, 5, -1, 0);
    n_checks++; if (timed_out) $display("[TB] FAIL abort_timeout got 1 want 0"); else n_pass++;
    n_checks++; if (n_done !== 0) $display("[TB] FAIL abort_done got %0d want 0", n_done); else n_pass++;
    n_checks++; if (end_mv !== 1'b0) $display("[TB] FAIL abort_m_valid got %b want 0", end_mv); else n_pass++;
    n_checks++; if (end_busy !== 1'b0) $display("[TB] FAIL abort_busy got %b want 0", end_busy); else n_pass++;
    run_frame(16, 80, 2, -1, -1, 0);
    n_checks++; if (n_clear !== 1) $display("[TB] FAIL abort_replay_clear got %0d want 1", n_clear); else n_pass++;
    n_checks++; if (n_out !== 16) $display("[TB] FAIL abort_replay_out got %0d want 16", n_out); else n_pass++;
    n_checks++; if (n_data_err !== 0) $display("[TB] FAIL abort_replay_data errors got %0d want 0", n_data_err); else n_pass++;
    n_checks++; if (n_done !== 1) $display("[TB] FAIL abort_replay_done got %0d want 1", n_done); else n_pass++;
  endtask

  task automatic test_start_ignored();
    run_frame(12, 70, 2, -1, 4, 0);
    n_checks++; if (timed_out) $display("[TB] FAIL busy_start_timeout got 1 want 0"); else n_pass++;
    n_checks++; if (n_run_ce !== 12) $display("[TB] FAIL busy_start_run_ce got %0d want 12", n_run_ce); else n_pass++;
    n_checks++; if (n_out !== 12) $display("[TB] FAIL busy_start_out got %0d want 12", n_out); else n_pass++;
    n_checks++; if (n_data_err !== 0) $display("[TB] FAIL busy_start_data errors got %0d want 0", n_data_err); else n_pass++;
    n_checks++; if (n_done !== 1) $display("[TB] FAIL busy_start_done got %0d want 1", n_done); else n_pass++;
  endtask

  task automatic test_reset_mid_flush();
    run_frame(10, 100, 0, -1, -1, 1);
    n_checks++; if (rst_hit !== 1'b1) $display("[TB] FAIL flush_reset_reached got %b want 1", rst_hit); else n_pass++;
    n_checks++; if (rst_vec !== 8'h00) $display("[TB] FAIL flush_reset_outputs got %b want 00000000", rst_vec); else n_pass++;
    n_checks++; if (n_done !== 0) $display("[TB] FAIL flush_reset_done got %0d want 0", n_done); else n_pass++;
    run_frame(10, 100, 0, -1, -1, 0);
    n_checks++; if (n_clear !== 1) $display("[TB] FAIL post_reset_clear got %0d want 1", n_clear); else n_pass++;
    n_checks++; if (n_out !== 10) $display("[TB] FAIL post_reset_out got %0d want 10", n_out); else n_pass++;
    n_checks++; if (n_data_err !== 0) $display("[TB] FAIL post_reset_data errors got %0d want 0", n_data_err); else n_pass++;
    n_checks++; if (n_done !== 1) $display("[TB] FAIL post_reset_done got %0d want 1", n_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_long_frame();
    test_backpressure();
    test_random_frames();
    test_zero_len();
    test_abort();
    test_start_ignored();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
